add_resp_checker: RTL and testbench

ADD_RESP_CHECKER -- requirements
Module: add_resp_checker

---
 rtl/add_chk_pkg.sv | 12 +
 rtl/nibble_add4.sv | 19 +
 rtl/add_resp_checker.sv | 172 +++++++++++++++++
 tb/tb_add_resp_checker.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/add_chk_pkg.sv
// Shared constants and FSM state type for the adder response checker.
package add_chk_pkg;
  localparam int WIDTH = 16;
  localparam int NIB   = 4;
  localparam int NNIB  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    CMP  = 2'd2
  } state_t;
endpackage

// File: rtl/nibble_add4.sv
// 4-bit ripple-carry slice; the checker walks one of these across the operands.
module nibble_add4 (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  input  logic       i_ci,
  output logic [3:0] o_s,
  output logic       o_co
);
  always_comb begin
    logic w_c;
    w_c = i_ci;
    o_s = '0;
    for (int i = 0; i < 4; i++) begin
      o_s[i] = i_a[i] ^ i_b[i] ^ w_c;
      w_c    = (i_a[i] & i_b[i]) | (w_c & (i_a[i] ^ i_b[i]));
    end
    o_co = w_c;
  end
endmodule

// File: rtl/add_resp_checker.sv
// Recomputes a 16-bit add one nibble per cycle and compares it with the response
// of the adder under test. Handshake: a transaction transfers on a rising edge
// where i_in_valid && o_in_ready; the source holds its data until then.
module add_resp_checker
  import add_chk_pkg::*;
#(
  parameter int CHK_GP = 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cin,
  input  logic [WIDTH-1:0] i_sum,
  input  logic             i_g,
  input  logic             i_p,
  input  logic             i_clr,
  output logic             o_done,
  output logic             o_mismatch,
  output logic [WIDTH-1:0] o_exp_sum,
  output logic             o_exp_cout,
  output logic [WIDTH-1:0] o_pass_cnt,
  output logic [WIDTH-1:0] o_fail_cnt,
  output logic             o_any_fail,
  output state_t           o_state
);
  state_t           r_state, w_next;
  logic [1:0]       r_nib;
  logic [WIDTH-1:0] r_a, r_b, r_sum, r_acc1, r_acc0;
  logic             r_g, r_p, r_c1, r_c0;
  logic [WIDTH-1:0] r_exp_sum, r_pass_cnt, r_fail_cnt;
  logic             r_exp_cout, r_mismatch, r_any_fail;

  logic             w_ready, w_done, w_last;
  logic [3:0]       w_base;
  logic [NIB-1:0]   w_s1, w_s0;
  logic             w_co1, w_co0, w_exp_p, w_mis;
  logic [WIDTH-1:0] w_fin1, w_fin0;

  assign w_base = {r_nib, 2'b00};

  nibble_add4 u_chain1 (
    .i_a (r_a[w_base +: NIB]),
    .i_b (r_b[w_base +: NIB]),
    .i_ci(r_c1),
    .o_s (w_s1),
    .o_co(w_co1)
  );

  nibble_add4 u_chain0 (
    .i_a (r_a[w_base +: NIB]),
    .i_b (r_b[w_base +: NIB]),
    .i_ci(r_c0),
    .o_s (w_s0),
    .o_co(w_co0)
  );

  // Full results as they stand once the current nibble is merged in.
  always_comb begin
    w_fin1 = r_acc1;
    w_fin0 = r_acc0;
    w_fin1[w_base +: NIB] = w_s1;
    w_fin0[w_base +: NIB] = w_s0;
  end

  // A+B with no carry-in is all ones exactly when B == ~A, i.e. every bit propagates.
  assign w_exp_p = (w_fin0 == '1);
  assign w_mis   = (r_sum != w_fin1) ||
                   ((CHK_GP != 0) && ((r_g != w_co0) || (r_p != w_exp_p)));

  always_comb begin
    w_next  = r_state;
    w_ready = 1'b0;
    w_done  = 1'b0;
    w_last  = 1'b0;
    case (r_state)
      IDLE: begin
        w_ready = 1'b1;
        if (i_in_valid) w_next = CALC;
      end
      CALC: begin
        if (r_nib == 2'(NNIB - 1)) begin
          w_last = 1'b1;
          w_next = CMP;
        end
      end
      CMP: begin
        w_done = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  // Result registers load on the last CALC edge so they are valid alongside o_done.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_nib      <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_sum      <= '0;
      r_g        <= 1'b0;
      r_p        <= 1'b0;
      r_c1       <= 1'b0;
      r_c0       <= 1'b0;
      r_acc1     <= '0;
      r_acc0     <= '0;
      r_exp_sum  <= '0;
      r_exp_cout <= 1'b0;
      r_mismatch <= 1'b0;
    end else if (w_ready && i_in_valid) begin
      r_nib  <= '0;
      r_a    <= i_a;
      r_b    <= i_b;
      r_sum  <= i_sum;
      r_g    <= i_g;
      r_p    <= i_p;
      r_c1   <= i_cin;
      r_c0   <= 1'b0;
      r_acc1 <= '0;
      r_acc0 <= '0;
    end else if (r_state == CALC) begin
      r_acc1 <= w_fin1;
      r_acc0 <= w_fin0;
      r_c1   <= w_co1;
      r_c0   <= w_co0;
      r_nib  <= r_nib + 2'd1;
      if (w_last) begin
        r_exp_sum  <= w_fin1;
        r_exp_cout <= w_co1;
        r_mismatch <= w_mis;
      end
    end
  end

  // Clear takes priority over the count of a coincident completion.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pass_cnt <= '0;
      r_fail_cnt <= '0;
      r_any_fail <= 1'b0;
    end else if (i_clr) begin
      r_pass_cnt <= '0;
      r_fail_cnt <= '0;
      r_any_fail <= 1'b0;
    end else if (w_done) begin
      if (r_mismatch) begin
        r_any_fail <= 1'b1;
        if (r_fail_cnt != '1) r_fail_cnt <= r_fail_cnt + 16'd1;
      end else if (r_pass_cnt != '1) begin
        r_pass_cnt <= r_pass_cnt + 16'd1;
      end
    end
  end

  assign o_in_ready = w_ready;
  assign o_done     = w_done;
  assign o_mismatch = r_mismatch;
  assign o_exp_sum  = r_exp_sum;
  assign o_exp_cout = r_exp_cout;
  assign o_pass_cnt = r_pass_cnt;
  assign o_fail_cnt = r_fail_cnt;
  assign o_any_fail = r_any_fail;
  assign o_state    = r_state;
endmodule

// File: tb/tb_add_resp_checker.sv
// Directed bench for add_resp_checker: one instance compares G/P, a second ignores them.
module tb_add_resp_checker;
  import add_chk_pkg::*;

  logic        clk, rst_n, in_valid, cin, g, p, clr;
  logic [15:0] a, b, sum;
  logic        rdy0, done0, mis0, cout0, any0;
  logic        rdy1, done1, mis1, cout1, any1;
  logic [15:0] esum0, pass0, fail0, esum1, pass1, fail1;
  state_t      st0, st1;

  add_resp_checker #(.CHK_GP(1)) dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(in_valid), .o_in_ready(rdy0),
    .i_a(a), .i_b(b), .i_cin(cin), .i_sum(sum), .i_g(g), .i_p(p), .i_clr(clr),
    .o_done(done0), .o_mismatch(mis0), .o_exp_sum(esum0), .o_exp_cout(cout0),
    .o_pass_cnt(pass0), .o_fail_cnt(fail0), .o_any_fail(any0), .o_state(st0)
  );

  add_resp_checker #(.CHK_GP(0)) dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(in_valid), .o_in_ready(rdy1),
    .i_a(a), .i_b(b), .i_cin(cin), .i_sum(sum), .i_g(g), .i_p(p), .i_clr(clr),
    .o_done(done1), .o_mismatch(mis1), .o_exp_sum(esum1), .o_exp_cout(cout1),
    .o_pass_cnt(pass1), .o_fail_cnt(fail1), .o_any_fail(any1), .o_state(st1)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  typedef struct {
    logic [15:0] a, b;
    logic        cin;
    logic [15:0] sum;
    logic        g, p;
    logic [15:0] e_sum;
    logic        e_cout;
    logic        e_mis_gp;
    logic        e_mis_nogp;
  } vec_t;

  vec_t        vecs[10];
  logic [15:0] exp_q[$];
  int          n_checks = 0;
  int          n_err    = 0;
  logic [15:0] m_pass0, m_fail0, m_pass1, m_fail1;
  logic        m_any0, m_any1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  task automatic model_clear();
    m_pass0 = '0; m_fail0 = '0; m_any0 = 1'b0;
    m_pass1 = '0; m_fail1 = '0; m_any1 = 1'b0;
  endtask

  task automatic chk_cnt();
    chk("pass_cnt0", pass0, m_pass0);
    chk("fail_cnt0", fail0, m_fail0);
    chk("any_fail0", any0, m_any0);
    chk("pass_cnt1", pass1, m_pass1);
    chk("fail_cnt1", fail1, m_fail1);
    chk("any_fail1", any1, m_any1);
  endtask

  // ---------------- driver ----------------
  task automatic drive_vec(input vec_t v);
    a = v.a; b = v.b; cin = v.cin; sum = v.sum; g = v.g; p = v.p;
    in_valid = 1'b1;
  endtask

  task automatic run_vec(input vec_t v, input bit clr_at_done);
    int          cyc;
    bit          seen;
    logic [15:0] e;
    @(negedge clk);
    drive_vec(v);
    cyc = 0;
    while (!rdy0 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk("accept_ready", rdy0, 1'b1);
    exp_q.push_back(v.e_sum);
    @(negedge clk);
    // Cycle 1: the captured copy must be used, so scramble the source.
    in_valid = 1'b0;
    a = 16'($urandom); b = 16'($urandom); sum = 16'($urandom);
    cin = 1'($urandom); g = 1'($urandom); p = 1'($urandom);
    cyc  = 1;
    seen = 1'b0;
    while (cyc <= 8 && !seen) begin
      if (done0) seen = 1'b1;
      else begin
        chk("busy_ready", rdy0, 1'b0);
        @(negedge clk);
        cyc++;
      end
    end
    chk("done_seen", seen, 1'b1);
    if (seen) begin
      chk("done_cycle", cyc, 5);
      chk("done1", done1, 1'b1);
      chk("ready_in_done", rdy0, 1'b0);
      e = exp_q.size() > 0 ? exp_q.pop_front() : 16'hxxxx;
      chk("exp_sum0", esum0, e);
      chk("exp_sum1", esum1, e);
      chk("exp_cout0", cout0, v.e_cout);
      chk("exp_cout1", cout1, v.e_cout);
      chk("mismatch_gp", mis0, v.e_mis_gp);
      chk("mismatch_nogp", mis1, v.e_mis_nogp);
      if (clr_at_done) begin
        clr = 1'b1;
        model_clear();
      end else begin
        if (v.e_mis_gp) begin m_fail0 = sat_inc(m_fail0); m_any0 = 1'b1; end
        else m_pass0 = sat_inc(m_pass0);
        if (v.e_mis_nogp) begin m_fail1 = sat_inc(m_fail1); m_any1 = 1'b1; end
        else m_pass1 = sat_inc(m_pass1);
      end
      @(negedge clk);
      clr = 1'b0;
      chk("ready_after", rdy0, 1'b1);
      chk("done_after", done0, 1'b0);
      chk("mis_hold", mis0, v.e_mis_gp);
      chk("sum_hold", esum0, v.e_sum);
      chk_cnt();
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int ndone;
    //              a        b        cin   sum      g     p     e_sum    cout  mis_gp mis_nogp
    vecs[0] = '{16'h0001, 16'hFFFF, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{16'h1234, 16'h4321, 1'b1, 16'h5555, 1'b0, 1'b0, 16'h5556, 1'b0, 1'b1, 1'b1};
    vecs[2] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0};
    vecs[3] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{16'hAAAA, 16'h5555, 1'b0, 16'hFFFF, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{16'hAAAA, 16'h5555, 1'b1, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0};
    vecs[7] = '{16'h1111, 16'h2222, 1'b0, 16'h3333, 1'b1, 1'b0, 16'h3333, 1'b0, 1'b1, 1'b0};
    vecs[8] = '{16'h7FFF, 16'h0001, 1'b1, 16'h8001, 1'b0, 1'b0, 16'h8001, 1'b0, 1'b0, 1'b0};
    vecs[9] = '{16'hF0F0, 16'h0F0F, 1'b0, 16'hFFFF, 1'b0, 1'b0, 16'hFFFF, 1'b0, 1'b1, 1'b0};

    rst_n = 1'b0; in_valid = 1'b0; clr = 1'b0;
    a = '0; b = '0; cin = 1'b0; sum = '0; g = 1'b0; p = 1'b0;
    model_clear();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset state
    chk("rst_ready", rdy0, 1'b1);
    chk("rst_done", done0, 1'b0);
    chk("rst_mis", mis0, 1'b0);
    chk("rst_exp_sum", esum0, 16'h0000);
    chk("rst_exp_cout", cout0, 1'b0);
    chk("rst_state", st0, IDLE);
    chk_cnt();

    // Table-driven vectors
    for (int i = 0; i < 10; i++) run_vec(vecs[i], 1'b0);

    // Continuous valid: accepts every 6 cycles, ready low in cycles 1-5
    drive_vec(vecs[4]);
    for (int k = 0; k < 18; k++) begin
      chk("stream_ready", rdy0, (k % 6) == 0);
      chk("stream_done", done0, (k % 6) == 5);
      if ((k % 6) == 5) begin
        chk("stream_sum", esum0, 16'h0100);
        m_pass0 = sat_inc(m_pass0);
        m_pass1 = sat_inc(m_pass1);
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk_cnt();

    // Reset in cycle 3 of a check aborts it
    drive_vec(vecs[0]);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    exp_q.delete();
    model_clear();
    #1;
    chk("abort_ready", rdy0, 1'b1);
    chk("abort_done", done0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int k = 0; k < 8; k++) begin
      if (done0) ndone++;
      @(negedge clk);
    end
    chk("abort_no_done", ndone, 0);
    chk("abort_exp_sum", esum0, 16'h0000);
    chk_cnt();

    // Clear coincident with Done: check not counted, results still update
    run_vec(vecs[4], 1'b0);
    run_vec(vecs[1], 1'b1);
    run_vec(vecs[1], 1'b0);

    // Saturation of the pass counter
    @(negedge clk);
    force dut0.r_pass_cnt = 16'hFFFF;
    @(negedge clk);
    release dut0.r_pass_cnt;
    m_pass0 = 16'hFFFF;
    chk("forced_pass", pass0, 16'hFFFF);
    run_vec(vecs[0], 1'b0);
    chk("sat_pass", pass0, 16'hFFFF);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
